// File: rtl/fetch_queue_pkg.sv
// Shared constants and queue-operation helpers for the fetch queue.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] INSTR_STEP = 32'h0000_0004;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

  // Encodes the per-cycle queue activity for the occupancy update.
  function automatic q_op_e q_op(input logic push, input logic pop);
    return q_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fetch_queue_adder.sv
// Plain modulo-2^WIDTH adder used for the PC+4 computation.
module fetch_queue_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: circular buffer of {instr, pc}
// with flush, full back-pressure and head outputs taken from registered state.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       Instr_F,
  input  logic [WIDTH-1:0]       PC_F,
  input  logic                   Valid_F,
  output logic                   PC_WrEn,
  input  logic                   Flush,
  input  logic                   D_Ready,
  output logic [WIDTH-1:0]       Instr_D,
  output logic [WIDTH-1:0]       PC_D,
  output logic [WIDTH-1:0]       PCPlus4_D,
  output logic                   Valid_D,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;
  q_op_e            op;
  logic [WIDTH-1:0] pc_head;
  logic [WIDTH-1:0] pc_next;

  assign PC_WrEn = (count_q < CW'(DEPTH));
  assign Valid_D = (count_q != '0);
  assign Count   = count_q;

  // Flush wins over both sides; a full queue never pushes even when popping.
  assign push = Valid_F && PC_WrEn && !Flush;
  assign pop  = Valid_D && D_Ready && !Flush;
  assign op   = q_op(push, pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      instr_mem <= '{default: '0};
      pc_mem    <= '{default: '0};
    end else if (Flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        instr_mem[tail] <= Instr_F;
        pc_mem[tail]    <= PC_F;
        tail            <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case (op)
        OP_PUSH: count_q <= count_q + CW'(1);
        OP_POP:  count_q <= count_q - CW'(1);
        OP_IDLE: count_q <= count_q;
        OP_BOTH: count_q <= count_q;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pc_head = pc_mem[head];

  fetch_queue_adder #(.WIDTH(WIDTH)) u_pc_plus4 (
    .a   (pc_head),
    .b   (WIDTH'(INSTR_STEP)),
    .sum (pc_next)
  );

  // Empty queue presents a nop at PC 0 so decode sees a clean bubble.
  assign Instr_D   = Valid_D ? instr_mem[head] : WIDTH'(NOP_INSTR);
  assign PC_D      = Valid_D ? pc_head         : '0;
  assign PCPlus4_D = Valid_D ? pc_next         : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] Instr_F;
  logic [WIDTH-1:0] PC_F;
  logic             Valid_F;
  logic             PC_WrEn;
  logic             Flush;
  logic             D_Ready;
  logic [WIDTH-1:0] Instr_D;
  logic [WIDTH-1:0] PC_D;
  logic [WIDTH-1:0] PCPlus4_D;
  logic             Valid_D;
  logic [2:0]       Count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .Instr_F   (Instr_F),
    .PC_F      (PC_F),
    .Valid_F   (Valid_F),
    .PC_WrEn   (PC_WrEn),
    .Flush     (Flush),
    .D_Ready   (D_Ready),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PCPlus4_D (PCPlus4_D),
    .Valid_D   (Valid_D),
    .Count     (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr();
    return (model_q.size() != 0) ? model_q[0].instr : 32'h0;
  endfunction

  function automatic logic [31:0] exp_pc();
    return (model_q.size() != 0) ? model_q[0].pc : 32'h0;
  endfunction

  function automatic logic [31:0] exp_pc4();
    return (model_q.size() != 0) ? model_q[0].pc + 32'd4 : 32'h0;
  endfunction

  // One clock: inputs applied now, model advanced after the edge.
  task automatic cycle(input logic vf, input logic [31:0] pc, input logic dr, input logic fl);
    logic do_push;
    logic do_pop;
    Valid_F = vf;
    PC_F    = pc;
    Instr_F = $urandom;
    D_Ready = dr;
    Flush   = fl;
    do_push = vf && (model_q.size() < DEPTH) && !fl;
    do_pop  = dr && (model_q.size() > 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{instr: Instr_F, pc: pc});
    end
    Valid_F = 1'b0;
    D_Ready = 1'b0;
    Flush   = 1'b0;
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    Valid_F = 1'b0;
    D_Ready = 1'b0;
    Flush   = 1'b0;
    PC_F    = '0;
    Instr_F = '0;
    model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (Count !== 3'd0 || Valid_D !== 1'b0 || PC_WrEn !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: Count=%0d Valid_D=%b PC_WrEn=%b, need 0/0/1", Count, Valid_D, PC_WrEn);
    end
    n_checks++;
    if (Instr_D !== 32'h0 || PC_D !== 32'h0 || PCPlus4_D !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: Instr_D=%h PC_D=%h PCPlus4_D=%h, need all zero", Instr_D, PC_D, PCPlus4_D);
    end
  endtask

  task automatic test_two_push();
    apply_reset();
    cycle(1'b1, 32'h3000, 1'b0, 1'b0);
    cycle(1'b1, 32'h3004, 1'b0, 1'b0);
    n_checks++;
    if (Count !== 3'd2 || Valid_D !== 1'b1 || PC_D !== 32'h3000 || PCPlus4_D !== 32'h3004) begin
      n_fail++;
      $display("FAIL two_push: Count=%0d Valid_D=%b PC_D=%h PCPlus4_D=%h, need 2/1/3000/3004",
               Count, Valid_D, PC_D, PCPlus4_D);
    end
    n_checks++;
    if (Instr_D !== exp_instr()) begin
      n_fail++;
      $display("FAIL two_push_instr: Instr_D=%h, need %h", Instr_D, exp_instr());
    end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    n_checks++;
    if (Count !== 3'd4 || PC_WrEn !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: Count=%0d PC_WrEn=%b, need 4/0", Count, PC_WrEn);
    end
    cycle(1'b1, 32'h3010, 1'b0, 1'b0);
    n_checks++;
    if (Count !== 3'd4 || PC_D !== 32'h3000) begin
      n_fail++;
      $display("FAIL full_drop: Count=%0d PC_D=%h, need 4/3000", Count, PC_D);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (PC_D !== 32'h3000 + 32'(4 * i) || Instr_D !== exp_instr()) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: PC_D=%h Instr_D=%h, need %h/%h",
                 i, PC_D, Instr_D, 32'h3000 + 32'(4 * i), exp_instr());
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_checks++;
    if (Count !== 3'd0 || Valid_D !== 1'b0 || Instr_D !== 32'h0 || PC_WrEn !== 1'b1) begin
      n_fail++;
      $display("FAIL drained_empty: Count=%0d Valid_D=%b Instr_D=%h PC_WrEn=%b, need 0/0/0/1",
               Count, Valid_D, Instr_D, PC_WrEn);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (Count !== 3'd0) begin
      n_fail++;
      $display("FAIL empty_pop_ignored: Count=%0d, need 0", Count);
    end
  endtask

  task automatic test_full_pop_push();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'h3010, 1'b1, 1'b0);
    n_checks++;
    if (Count !== 3'd3 || PC_D !== 32'h3004 || PC_WrEn !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop: Count=%0d PC_D=%h PC_WrEn=%b, need 3/3004/1", Count, PC_D, PC_WrEn);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    cycle(1'b1, 32'h3000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (PC_D !== 32'h3000 + 32'(4 * i) || Count !== 3'd1) begin
        n_fail++;
        $display("FAIL wrap[%0d]: PC_D=%h Count=%0d, need %h/1", i, PC_D, Count, 32'h3000 + 32'(4 * i));
      end
      cycle(1'b1, 32'h3004 + 32'(4 * i), 1'b1, 1'b0);
    end
    n_checks++;
    if (Count !== 3'd1 || PC_D !== 32'h3028 || Instr_D !== exp_instr()) begin
      n_fail++;
      $display("FAIL wrap_end: Count=%0d PC_D=%h Instr_D=%h, need 1/3028/%h", Count, PC_D, Instr_D, exp_instr());
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'h300C, 1'b1, 1'b1);
    n_checks++;
    if (Count !== 3'd0 || Valid_D !== 1'b0 || Instr_D !== 32'h0 || PC_WrEn !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: Count=%0d Valid_D=%b Instr_D=%h PC_WrEn=%b, need 0/0/0/1",
               Count, Valid_D, Instr_D, PC_WrEn);
    end
    cycle(1'b1, 32'h4000, 1'b0, 1'b0);
    n_checks++;
    if (Count !== 3'd1 || PC_D !== 32'h4000 || Instr_D !== exp_instr()) begin
      n_fail++;
      $display("FAIL post_flush_push: Count=%0d PC_D=%h Instr_D=%h, need 1/4000/%h",
               Count, PC_D, Instr_D, exp_instr());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    cycle(1'b1, 32'h3000, 1'b0, 1'b0);
    cycle(1'b1, 32'h3004, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_q.delete();
    #1;
    n_checks++;
    if (Count !== 3'd0 || Valid_D !== 1'b0 || PC_D !== 32'h0 || PC_WrEn !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: Count=%0d Valid_D=%b PC_D=%h PC_WrEn=%b, need 0/0/0/1",
               Count, Valid_D, PC_D, PC_WrEn);
    end
    #1;
    reset = 1'b1;
    cycle(1'b1, 32'h5000, 1'b0, 1'b0);
    n_checks++;
    if (Count !== 3'd1 || PC_D !== 32'h5000) begin
      n_fail++;
      $display("FAIL first_push_after_reset: Count=%0d PC_D=%h, need 1/5000", Count, PC_D);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    apply_reset();
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      logic vf;
      logic dr;
      logic fl;
      vf = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 29) == 0);
      if (vf && model_q.size() < DEPTH && !fl) begin
        cycle(vf, pc, dr, fl);
        pc = pc + 32'd4;
      end else begin
        cycle(vf, pc, dr, fl);
      end
      n_checks++;
      if (Count !== 3'(model_q.size()) || Valid_D !== (model_q.size() != 0) ||
          PC_WrEn !== (model_q.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: Count=%0d Valid_D=%b PC_WrEn=%b, need %0d/%b/%b",
                 i, Count, Valid_D, PC_WrEn, model_q.size(), model_q.size() != 0, model_q.size() < DEPTH);
      end
      n_checks++;
      if (Instr_D !== exp_instr() || PC_D !== exp_pc() || PCPlus4_D !== exp_pc4()) begin
        n_fail++;
        $display("FAIL rand_head[%0d]: Instr_D=%h PC_D=%h PCPlus4_D=%h, need %h/%h/%h",
                 i, Instr_D, PC_D, PCPlus4_D, exp_instr(), exp_pc(), exp_pc4());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_two_push();
    test_fill_drain();
    test_full_pop_push();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter: WIDTH, default 32, instruction and PC width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Instr_F  input  WIDTH  instruction word presented by the fetch stage.
REQ-006 PC_F  input  WIDTH  PC of Instr_F.
REQ-007 Valid_F  input  1  Instr_F/PC_F hold a real fetched instruction this cycle.
REQ-008 PC_WrEn  output  1  PC write enable to fetch; 1 = queue can accept, 0 = stall fetch.
REQ-009 Flush  input  1  branch/jump redirect; discard all queued instructions.
REQ-010 D_Ready  input  1  decode consumes the head entry this cycle.
REQ-011 Instr_D  output  WIDTH  head instruction; 32'h00000000 (nop) when empty.
REQ-012 PC_D  output  WIDTH  head PC; 0 when empty.
REQ-013 PCPlus4_D  output  WIDTH  PC_D + 4 modulo 2^WIDTH when valid; 0 when empty.
REQ-014 Valid_D  output  1  head entry valid.
REQ-015 Count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Circular buffer of DEPTH {instr, pc} entries with head pointer, tail pointer, and occupancy counter.
REQ-017 PC_WrEn = (Count < DEPTH); combinational from registered Count only; no dependency on D_Ready.
REQ-018 Push occurs when Valid_F && PC_WrEn && !Flush; writes {Instr_F, PC_F} at tail; tail advances by 1 modulo DEPTH.
REQ-019 Pop occurs when Valid_D && D_Ready && !Flush; head advances by 1 modulo DEPTH.
REQ-020 A pushed entry appears on Instr_D no earlier than the next cycle; no write-to-read bypass.
REQ-021 Simultaneous push and pop: Count unchanged; both pointers advance.
REQ-022 Full (Count == DEPTH): PC_WrEn = 0; a same-cycle pop does not enable a push; the pop alone proceeds.
REQ-023 Empty (Count == 0): Valid_D = 0; Instr_D/PC_D/PCPlus4_D = 0; D_Ready is ignored.
REQ-024 Flush has priority over push and pop; the next cycle has Count = 0, head = tail = 0, Valid_D = 0.
REQ-025 Valid_F while PC_WrEn = 0: input is dropped; fetch holds its PC and re-presents the input.
REQ-026 Pointer wrap from DEPTH-1 to 0 is seamless; no entry is lost or duplicated.
REQ-027 Outputs are combinational from registered head state only; no combinational path from D_Ready to Instr_D.

Reset
REQ-028 Reset asserted (reset = 0): Count = 0, head = tail = 0, all entries = 0, Valid_D = 0, PC_WrEn = 1.
REQ-029 Reset asserted mid-operation: pending entries are discarded immediately (asynchronous), regardless of clk.
REQ-030 Deassertion is synchronised by the integrating top; the first push is accepted on the first edge after release.

Structure
REQ-031 The shared constants file holds NOP_INSTR = 32'h00000000 and INSTR_STEP = 32'h00000004.
REQ-032 PCPlus4_D is produced by one instance of the team's 32-bit Adder sub-module (PC_D + INSTR_STEP), gated to 0 when empty.
REQ-033 Target size is 120-400 lines of RTL; the block contains no instruction memory and no PC register.

Verification
REQ-034 Reset, then push PC 0x3000/0x3004 on consecutive cycles, D_Ready = 0 -> Count = 2, Valid_D = 1, PC_D = 0x3000, PCPlus4_D = 0x3004.
REQ-035 Push 4 entries with D_Ready = 0 -> Count = 4, PC_WrEn = 0; a fifth Valid_F with PC 0x3010 is dropped; draining 4 pops yields 0x3000..0x300C in order.
REQ-036 Full queue with D_Ready = 1 and Valid_F = 1 in the same cycle -> next Count = 3, head PC = 0x3004, PC_WrEn = 1.
REQ-037 Steady push+pop for 10 cycles (pointer wrap) -> Count constant at 1, PCs delivered in order 0x3000..0x3024.
REQ-038 Count = 3 with Flush = 1, Valid_F = 1, D_Ready = 1 -> next cycle Count = 0, Valid_D = 0, Instr_D = 0.
REQ-039 reset pulsed low between clock edges with Count = 2 -> Count = 0 and Valid_D = 0 immediately, before the next edge.
